ps2_host_tx: RTL

- Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED for Set LEDs or 0xFF for Reset.
- Shares the open-drain keyClk/keyData lines with the existing receive path. It drives each line only through an active-high output-enable, which pulls the line low.
- Runs entirely in the sysClk domain. The keyboard clock is treated as a sampled data signal, not as a clock.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_host_tx_if.sv | 29 ++
 rtl/ps2_line_sync.sv | 51 +++++
 rtl/ps2_host_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host-to-device transmitter:
//   ps2_tx_state_t  - transmitter FSM states
//   PS2_DATA_BITS   - data bits per PS/2 frame
//   PS2_FRAME_FALLS - device clock falls from start bit to stop bit
//   odd_parity()    - PS/2 parity bit for a data byte
// -----------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    ACK,
    WAITIDLE
  } ps2_tx_state_t;

  localparam int PS2_DATA_BITS   = 8;
  localparam int PS2_FRAME_FALLS = 10;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// -----------------------------------------------------------------------------
// ps2_host_tx_if
// Command-side handshake of the PS/2 host transmitter.
//   txData  [7:0] command byte, taken when txValid && txReady
//   txValid       request to send txData
//   txReady       transmitter is idle and can take a byte
//   busy          transfer in progress
//   txDone        one-cycle pulse, byte acknowledged by the device
//   txErr         one-cycle pulse, NACK or timeout
// master = command source, slave = transmitter.
// -----------------------------------------------------------------------------
interface ps2_host_tx_if;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;
  logic       busy;
  logic       txDone;
  logic       txErr;

  modport master (
    output txData, txValid,
    input  txReady, busy, txDone, txErr
  );

  modport slave (
    input  txData, txValid,
    output txReady, busy, txDone, txErr
  );
endinterface

// File: rtl/ps2_line_sync.sv
// -----------------------------------------------------------------------------
// ps2_line_sync
// Brings the raw open-drain PS/2 clock and data lines into the sysClk domain
// and flags falling edges of the keyboard clock. Shared with the receive path.
//   sysClk    system clock
//   reset     asynchronous active-low reset
//   keyClkIn  raw PS/2 clock line
//   keyDataIn raw PS/2 data line
//   clkFall   one-cycle pulse, SYNC_STAGES + 1 cycles after a raw 1->0 edge
//   clkSync   synchronised clock line
//   dataSync  synchronised data line
// SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sysClk,
  input  logic reset,
  input  logic keyClkIn,
  input  logic keyDataIn,
  output logic clkFall,
  output logic clkSync,
  output logic dataSync
);

  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] data_sr;
  logic                   clk_prev;

  // Chains reset to 1, the idle level of both lines, so leaving reset never
  // looks like a clock fall.
  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      clk_sr   <= '1;
      data_sr  <= '1;
      clk_prev <= 1'b1;
      clkFall  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the value from
      // before this edge; blocking ones would collapse the chain into a wire.
      clk_sr   <= {clk_sr[SYNC_STAGES-2:0], keyClkIn};
      data_sr  <= {data_sr[SYNC_STAGES-2:0], keyDataIn};
      clk_prev <= clk_sr[SYNC_STAGES-1];
      clkFall  <= clk_prev & ~clk_sr[SYNC_STAGES-1];
    end
  end

  assign clkSync  = clk_sr[SYNC_STAGES-1];
  assign dataSync = data_sr[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED Set LEDs,
// 0xFF Reset) to the keyboard over the shared open-drain keyClk/keyData lines.
// Lines are only ever pulled low through active-high output enables. The
// keyboard clock is sampled as data; all logic runs on sysClk.
//   sysClk     system clock
//   reset      asynchronous active-low reset
//   tx         command handshake (ps2_host_tx_if.slave)
//   keyClkIn   raw PS/2 clock line
//   keyDataIn  raw PS/2 data line
//   keyClkOe   1 = pull keyClk low
//   keyDataOe  1 = pull keyData low
// Build option: define PS2_TX_RETRY_EN to re-send the byte once after a NACK
// or timeout; txErr then pulses only if the retry fails as well.
// INHIBIT_CYCLES must be at least 2.
// -----------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic         sysClk,
  input  logic         reset,
  ps2_host_tx_if.slave tx,
  input  logic         keyClkIn,
  input  logic         keyDataIn,
  output logic         keyClkOe,
  output logic         keyDataOe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                             : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX) + 1;
  localparam int BW = $clog2(PS2_FRAME_FALLS) + 1;
  localparam int SW = $clog2(PS2_DATA_BITS + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES);
  localparam logic [CW-1:0] INH_PRE  = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  // Bit count seen at the stop-bit fall (falls 1..9 carry data and parity).
  localparam logic [BW-1:0] STOP_CNT = BW'(PS2_FRAME_FALLS - 1);

  ps2_tx_state_t          state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [PS2_DATA_BITS:0] shreg_q, shreg_d;
  logic                   clk_oe_q, clk_oe_d;
  logic                   data_oe_q, data_oe_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   fail;
  logic                   active;
`ifdef PS2_TX_RETRY_EN
  logic                   retried_q, retried_d;
`endif

  logic clk_fall, clk_sync, data_sync;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .sysClk   (sysClk),
    .reset    (reset),
    .keyClkIn (keyClkIn),
    .keyDataIn(keyDataIn),
    .clkFall  (clk_fall),
    .clkSync  (clk_sync),
    .dataSync (data_sync)
  );

  // Line enables are registered, so the async reset releases both lines
  // immediately without waiting for a clock edge.
  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retried_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef PS2_TX_RETRY_EN
      retried_q <= retried_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fail      = 1'b0;
    active    = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retried_d = retried_q;
`endif

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        // txReady is high exactly in IDLE, so txValid alone means capture.
        if (tx.txValid) begin
          shreg_d  = {odd_parity(tx.txData), tx.txData};
          state_d  = INHIBIT;
          cnt_d    = CW'(1);
          clk_oe_d = 1'b1;
`ifdef PS2_TX_RETRY_EN
          retried_d = 1'b0;
`endif
        end
      end

      // cnt_q numbers the current clock-low cycle, 1..INHIBIT_CYCLES.
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d  = REQ;
          clk_oe_d = 1'b0;
          cnt_d    = '0;
          bit_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Start bit goes out during the final inhibit cycle.
          if (cnt_q == INH_PRE) data_oe_d = 1'b1;
        end
      end

      REQ, DATA: begin
        active = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (clk_fall) begin
          bit_d   = bit_q + 1'b1;
          state_d = DATA;
          if (bit_q == STOP_CNT) begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end else begin
            // Index by count instead of shifting so the byte survives a retry.
            data_oe_d = ~shreg_q[bit_q[SW-1:0]];
          end
        end
      end

      ACK: begin
        active = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (clk_fall) begin
          if (data_sync) fail = 1'b1;
          else           state_d = WAITIDLE;
        end
      end

      WAITIDLE: begin
        active = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Timeout overrides whatever the state logic decided this cycle.
    if (active && (cnt_q == TMO_LAST)) fail = 1'b1;

    if (fail) begin
      done_d    = 1'b0;
      bit_d     = '0;
      data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (!retried_q) begin
        retried_d = 1'b1;
        state_d   = INHIBIT;
        cnt_d     = CW'(1);
        clk_oe_d  = 1'b1;
      end else begin
        state_d  = IDLE;
        cnt_d    = '0;
        clk_oe_d = 1'b0;
        err_d    = 1'b1;
      end
`else
      state_d  = IDLE;
      cnt_d    = '0;
      clk_oe_d = 1'b0;
      err_d    = 1'b1;
`endif
    end
  end

  assign keyClkOe   = clk_oe_q;
  assign keyDataOe  = data_oe_q;
  assign tx.txDone  = done_q;
  assign tx.txErr   = err_q;
  assign tx.busy    = (state_q != IDLE);
  assign tx.txReady = (state_q == IDLE);

endmodule
